// File: rtl/tpu_inst_pkg.sv
// tpu_inst_pkg: shared widths, default depth and fetch FSM states for the instruction fetch unit.
package tpu_inst_pkg;
  localparam int DATA_W = 128;
  localparam int INST_DEPTH = 1024;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, PREF} state_t;
endpackage

// File: rtl/inst_pbuf.sv
// inst_pbuf: one-entry prefetch buffer (word, address, valid); inv clears valid and wins over wr.
module inst_pbuf #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = tpu_inst_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              inv,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      valid <= inv ? 1'b0 : (wr ? 1'b1 : valid);
      if (wr) begin
        addr <= wr_addr;
        data <= wr_data;
      end
    end
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-request instruction BRAM reader with range check.
// Defining INST_PREFETCH_EN adds a one-word next-address prefetch buffer.
module inst_fetch_unit import tpu_inst_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = tpu_inst_pkg::DATA_W,
  parameter int INST_DEPTH = tpu_inst_pkg::INST_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RD_START,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_DONE,
  output logic              RD_ERR,
  output logic              RD_BUSY,
  input  logic              INV,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout
);
  state_t state, next;
  logic [1:0] cnt;
  logic issued, err, pend, start, in_range, hit, lat_done, pf_ok;
  logic [ADDR_W-1:0] req_addr, pend_addr, addr;
  logic buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
`ifdef INST_PREFETCH_EN
  localparam bit PF = 1'b1;
  logic inv_seen;
  // an INV seen anywhere in PREF means the word being fetched may be stale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inv_seen <= 1'b0;
    else inv_seen <= state == PREF && (inv_seen || INV);
  end
  inst_pbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pbuf (
    .clk(clk),
    .rst(rst),
    .wr(state == PREF && issued && lat_done && !INV && !inv_seen),
    .inv(INV),
    .wr_addr(bram_addr),
    .wr_data(bram_dout),
    .valid(buf_valid),
    .addr(buf_addr),
    .data(buf_data)
  );
`else
  localparam bit PF = 1'b0;
  assign buf_valid = 1'b0;
  assign buf_addr = '0;
  assign buf_data = '0;
`endif
  assign start = pend || RD_START;
  assign addr = pend ? pend_addr : RD_ADDR;
  assign in_range = int'(addr) < INST_DEPTH;
  assign hit = buf_valid && buf_addr == addr && !INV;
  assign lat_done = cnt == 2'(RD_LAT - 1);
  assign pf_ok = PF && !err && (int'(req_addr) + 1 < INST_DEPTH);
  assign RD_DONE = state == RESP;
  assign RD_ERR = RD_DONE && err;
  assign RD_BUSY = state != IDLE;
  assign bram_en = state == ISSUE || (state == PREF && !issued);
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !start ? IDLE : (!in_range || hit) ? RESP : ISSUE;
      ISSUE:   next = WAIT;
      WAIT:    next = lat_done ? RESP : WAIT;
      RESP:    next = pf_ok ? PREF : IDLE;
      PREF:    next = (issued && lat_done) ? IDLE : PREF;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      issued <= 1'b0;
      err <= 1'b0;
      pend <= 1'b0;
      req_addr <= '0;
      pend_addr <= '0;
      bram_addr <= '0;
      RD_DATA <= '0;
    end else begin
      state <= next;
      cnt <= (state == WAIT || (state == PREF && issued)) ? cnt + 2'd1 : 2'd0;
      issued <= state == PREF;
      if (state == IDLE && start) begin
        req_addr <= addr;
        err <= !in_range;
        pend <= 1'b0;
        if (!in_range) RD_DATA <= '0;
        else if (hit) RD_DATA <= buf_data;
        else bram_addr <= addr;
      end
      if (state == WAIT && lat_done) RD_DATA <= bram_dout;
      if (state == RESP && pf_ok) bram_addr <= req_addr + ADDR_W'(1);
      if (state == PREF && RD_START) begin
        pend <= 1'b1;
        pend_addr <= RD_ADDR;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of miss/hit/INV/range/latency/reset behaviour
// on a RD_LAT=1 (ADDR_W=11) and a RD_LAT=2 (ADDR_W=10) instance.
module tb_inst_fetch_unit;
`ifdef INST_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam logic [127:0] D5 = {4{32'hA5A5A5A5}};
  localparam logic [127:0] D6 = {4{32'hA5A5A5A6}};
  localparam logic [127:0] D1023 = {4{32'hA5A5A7FF}};
  logic clk = 1'b0, rst = 1'b0, sel_v = 1'b0;
  logic a_start = 1'b0, a_inv = 1'b0, a_done, a_err, a_busy, a_en;
  logic [10:0] a_addr = '0, a_ba;
  logic [127:0] a_data, a_dout;
  logic b_start = 1'b0, b_inv = 1'b0, b_done, b_err, b_busy, b_en;
  logic [9:0] b_addr = '0, b_ba;
  logic [127:0] b_data, b_dout, b_p0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  inst_fetch_unit #(.ADDR_W(11), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .RD_START(a_start), .RD_ADDR(a_addr), .RD_DATA(a_data),
    .RD_DONE(a_done), .RD_ERR(a_err), .RD_BUSY(a_busy), .INV(a_inv),
    .bram_en(a_en), .bram_addr(a_ba), .bram_dout(a_dout)
  );
  inst_fetch_unit #(.ADDR_W(10), .RD_LAT(2)) u_b (
    .clk(clk), .rst(rst), .RD_START(b_start), .RD_ADDR(b_addr), .RD_DATA(b_data),
    .RD_DONE(b_done), .RD_ERR(b_err), .RD_BUSY(b_busy), .INV(b_inv),
    .bram_en(b_en), .bram_addr(b_ba), .bram_dout(b_dout)
  );
  function automatic logic [127:0] mem(input logic [10:0] a);
    return {4{32'hA5A5A5A0 | {21'b0, a}}};
  endfunction
  always @(posedge clk) begin
    if (a_en) a_dout <= mem(a_ba);
    if (b_en) b_p0 <= mem({1'b0, b_ba});
    b_dout <= b_p0;
  end
  wire o_done = sel_v ? b_done : a_done;
  wire o_err = sel_v ? b_err : a_err;
  wire o_busy = sel_v ? b_busy : a_busy;
  wire o_en = sel_v ? b_en : a_en;
  wire [10:0] o_ba = sel_v ? {1'b0, b_ba} : a_ba;
  wire [127:0] o_data = sel_v ? b_data : a_data;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic s, input logic [10:0] ad, input logic i);
    if (sel_v) begin
      b_start = s; b_addr = ad[9:0]; b_inv = i;
    end else begin
      a_start = s; a_addr = ad; a_inv = i;
    end
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_done"}, 128'(o_done), 0);
    chk({tag, "_err"}, 128'(o_err), 0);
    chk({tag, "_busy"}, 128'(o_busy), 0);
    chk({tag, "_en"}, 128'(o_en), 0);
    chk({tag, "_ba"}, 128'(o_ba), 0);
    chk({tag, "_data"}, o_data, 0);
  endtask
  // issue one request at the current negedge (cycle 0) and watch cycles 1..9
  task automatic rd(input string tag, input logic [10:0] ad, input logic i, input int exp_cyc,
                    input logic [127:0] exp_data, input logic exp_err, input int exp_en,
                    input logic [10:0] exp_ba);
    int done_cyc = 0, done_n = 0, en_n = 0;
    logic [127:0] d = '0;
    logic e = 1'b0;
    logic [10:0] ba = '1;
    drive(1'b1, ad, i);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (o_done) begin
        done_n++;
        if (done_cyc == 0) begin
          done_cyc = c; d = o_data; e = o_err;
        end
      end
      if (o_en) begin
        en_n++;
        if (ba == '1) ba = o_ba;
      end
      drive(1'b0, '0, 1'b0);
    end
    chk({tag, "_done_cycle"}, 128'(done_cyc), 128'(exp_cyc));
    chk({tag, "_done_count"}, 128'(done_n), 1);
    chk({tag, "_data"}, d, exp_data);
    chk({tag, "_err"}, 128'(e), 128'(exp_err));
    chk({tag, "_en_count"}, 128'(en_n), 128'(exp_en));
    chk({tag, "_first_bram_addr"}, 128'(ba), 128'(exp_ba));
    chk({tag, "_data_held"}, o_data, exp_data);
    chk({tag, "_idle_after"}, 128'(o_busy), 0);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    sel_v = 1'b0;
    rst_chk("reset_a");
    sel_v = 1'b1;
    rst_chk("reset_b");
    sel_v = 1'b0;
    rst = 1'b1;
    rd("miss5", 11'd5, 1'b0, 3, D5, 1'b0, PF ? 2 : 1, 11'd5);
    rd("hit6", 11'd6, 1'b0, PF ? 1 : 3, D6, 1'b0, 1, PF ? 11'd7 : 11'd6);
    rd("refill5", 11'd5, 1'b0, 3, D5, 1'b0, PF ? 2 : 1, 11'd5);
    rd("inv6", 11'd6, 1'b1, 3, D6, 1'b0, PF ? 2 : 1, 11'd6);
    rd("oor1024", 11'd1024, 1'b0, 1, 128'd0, 1'b1, 0, 11'h7FF);
    rd("edge1023", 11'd1023, 1'b0, 3, D1023, 1'b0, 1, 11'd1023);
    sel_v = 1'b1;
    rd("lat2_miss5", 11'd5, 1'b0, 4, D5, 1'b0, PF ? 2 : 1, 11'd5);
    drive(1'b1, 11'd9, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("busy_before_reset", 128'(b_busy), 1);
    rst = 1'b0;
    #1;
    rst_chk("reset_midflight");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_done_in_reset", 128'(b_done), 0);
    end
    rst = 1'b1;
    rd("post_reset6", 11'd6, 1'b0, 4, D6, 1'b0, PF ? 2 : 1, 11'd6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
